// File: rtl/motion_pkg.sv
// Shared types and helpers for the multi-channel motion classifier.
package motion_pkg;

    typedef enum logic {
        ST_STILL  = 1'b0,
        ST_MOVING = 1'b1
    } motion_state_t;

    // Widest supported sample; abs_diff works on sign-extended operands of this width.
    localparam int ABS_MAX_W = 32;

    // |a - b| with one extra bit, so the magnitude of any difference is representable.
    function automatic logic [ABS_MAX_W:0] abs_diff(
        input logic signed [ABS_MAX_W-1:0] a,
        input logic signed [ABS_MAX_W-1:0] b
    );
        logic [ABS_MAX_W:0] d;
        d = {a[ABS_MAX_W-1], a} - {b[ABS_MAX_W-1], b};
        return d[ABS_MAX_W] ? (~d + (ABS_MAX_W+1)'(1)) : d;
    endfunction

endpackage

// File: rtl/motion_channel.sv
// One sample channel: priming, delta magnitude and run-length hysteresis
// between STILL and MOVING.
module motion_channel
    import motion_pkg::*;
#(
    parameter int W         = 12,
    parameter int ENTER_CNT = 4,
    parameter int EXIT_CNT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid_i,
    input  logic signed [W-1:0] sample_i,
    input  logic        [W-1:0] threshold_i,
    output logic                ch_moving_o
);

    localparam int MAX_CNT = (ENTER_CNT > EXIT_CNT) ? ENTER_CNT : EXIT_CNT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] ENTER_LIM = CNT_W'(ENTER_CNT);
    localparam logic [CNT_W-1:0] EXIT_LIM  = CNT_W'(EXIT_CNT);

    logic signed [W-1:0] prev_q, prev_d;
    logic                primed_q, primed_d;
    motion_state_t       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [ABS_MAX_W:0]  delta;
    logic                above;
    logic [CNT_W-1:0]    cnt_inc;

    always_comb begin
        delta   = abs_diff(ABS_MAX_W'(sample_i), ABS_MAX_W'(prev_q));
        // A zero threshold makes every delta count as motion.
        above   = (delta >= (ABS_MAX_W+1)'(threshold_i));
        cnt_inc = cnt_q + CNT_W'(1);

        prev_d   = prev_q;
        primed_d = primed_q;
        state_d  = state_q;
        cnt_d    = cnt_q;

        if (sample_valid_i) begin
            prev_d = sample_i;
            if (!primed_q) begin
                primed_d = 1'b1;
            end else begin
                unique case (state_q)
                    ST_STILL: begin
                        if (!above) begin
                            cnt_d = '0;
                        end else if (cnt_inc == ENTER_LIM) begin
                            state_d = ST_MOVING;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    ST_MOVING: begin
                        if (above) begin
                            cnt_d = '0;
                        end else if (cnt_inc == EXIT_LIM) begin
                            state_d = ST_STILL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: begin
                        state_d = ST_STILL;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            state_q  <= ST_STILL;
            cnt_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ch_moving_o = (state_q == ST_MOVING);

endmodule

// File: rtl/motion_classifier_mc.sv
// Multi-channel motion classifier: combines per-channel flags (any/all),
// pulses on transitions and accumulates saturating still-seconds.
module motion_classifier_mc
    import motion_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int W         = 12,
    parameter int ENTER_CNT = 4,
    parameter int EXIT_CNT  = 8,
    parameter int CLK_HZ    = 100_000_000,
    parameter int TIMER_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     sample_valid,
    input  logic [N_CH*W-1:0]   sample,
    input  logic [W-1:0]        threshold,
    input  logic                mode_all,
    input  logic                clear_timer,
    output logic [N_CH-1:0]     ch_moving,
    output logic                moving,
    output logic                move_event,
    output logic                still_event,
    output logic [TIMER_W-1:0]  study_seconds
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
        return (&v) ? v : v + TIMER_W'(1);
    endfunction

    for (genvar i = 0; i < N_CH; i++) begin : gen_ch
        motion_channel #(
            .W         (W),
            .ENTER_CNT (ENTER_CNT),
            .EXIT_CNT  (EXIT_CNT)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .sample_valid_i (sample_valid[i]),
            .sample_i       (sample[i*W +: W]),
            .threshold_i    (threshold),
            .ch_moving_o    (ch_moving[i])
        );
    end

    logic               moving_q, moving_d;
    logic               move_evt_q, move_evt_d;
    logic               still_evt_q, still_evt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [TIMER_W-1:0] study_q, study_d;
    logic               tick;

    always_comb begin
        moving_d    = mode_all ? (&ch_moving) : (|ch_moving);
        move_evt_d  = moving_d & ~moving_q;
        still_evt_d = ~moving_d & moving_q;

        tick    = (div_q == DIV_LAST);
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        study_d = study_q;
        // The tick sees the registered classification of this same cycle.
        if (tick && !moving_q) begin
            study_d = sat_inc(study_q);
        end
        if (clear_timer) begin
            div_d   = '0;
            study_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            moving_q    <= 1'b0;
            move_evt_q  <= 1'b0;
            still_evt_q <= 1'b0;
            div_q       <= '0;
            study_q     <= '0;
        end else begin
            moving_q    <= moving_d;
            move_evt_q  <= move_evt_d;
            still_evt_q <= still_evt_d;
            div_q       <= div_d;
            study_q     <= study_d;
        end
    end

    assign moving        = moving_q;
    assign move_event    = move_evt_q;
    assign still_event   = still_evt_q;
    assign study_seconds = study_q;

endmodule

// File: tb/tb_motion_classifier_mc.sv
// Directed bench for motion_classifier_mc with hand-computed expectations.
module tb_motion_classifier_mc;

    localparam int N_CH = 2;
    localparam int W    = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   sample_valid;
    logic [N_CH*W-1:0] sample;
    logic [W-1:0]      threshold;
    logic              mode_all;
    logic              clear_timer;
    logic [N_CH-1:0]   ch_moving;
    logic              moving;
    logic              move_event;
    logic              still_event;
    logic [3:0]        study_seconds;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    motion_classifier_mc #(
        .N_CH      (N_CH),
        .W         (W),
        .ENTER_CNT (3),
        .EXIT_CNT  (4),
        .CLK_HZ    (10),
        .TIMER_W   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .threshold     (threshold),
        .mode_all      (mode_all),
        .clear_timer   (clear_timer),
        .ch_moving     (ch_moving),
        .moving        (moving),
        .move_event    (move_event),
        .still_event   (still_event),
        .study_seconds (study_seconds)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] mask, input int s0, input int s1);
        sample_valid = mask;
        sample       = {12'(s1), 12'(s0)};
        step(1);
        sample_valid = '0;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] chm, input logic mv,
                              input logic me, input logic se);
        check_eq({tag, ".ch_moving"},   32'(ch_moving),   32'(chm));
        check_eq({tag, ".moving"},      32'(moving),      32'(mv));
        check_eq({tag, ".move_event"},  32'(move_event),  32'(me));
        check_eq({tag, ".still_event"}, 32'(still_event), 32'(se));
    endtask

    initial begin
        rst          = 1'b0;
        sample_valid = '0;
        sample       = '0;
        threshold    = 12'd4;
        mode_all     = 1'b0;
        clear_timer  = 1'b0;
        step(2);
        check_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0);
        check_eq("reset.study", 32'(study_seconds), 32'd0);

        // Timer: first tick 10 cycles after release, saturates at 15
        rst = 1'b1;
        step(35);
        check_eq("timer.35cyc", 32'(study_seconds), 32'd3);
        step(200);
        check_eq("timer.sat", 32'(study_seconds), 32'd15);
        step(4);
        clear_timer = 1'b1;
        step(1);
        clear_timer = 1'b0;
        check_eq("timer.clear_on_tick", 32'(study_seconds), 32'd0);
        step(9);
        check_eq("timer.div_restart_pre", 32'(study_seconds), 32'd0);
        step(1);
        check_eq("timer.div_restart_tick", 32'(study_seconds), 32'd1);

        // Priming and entering MOVING on ch0
        send(2'b01, 100, 0);
        check_outs("prime", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1);
        check_outs("prime.t2", 2'b00, 1'b0, 1'b0, 1'b0);
        send(2'b01, 110, 0);
        check_eq("enter.110", 32'(ch_moving), 32'd0);
        send(2'b01, 120, 0);
        check_eq("enter.120", 32'(ch_moving), 32'd0);
        send(2'b01, 130, 0);
        check_outs("enter.130", 2'b01, 1'b0, 1'b0, 1'b0);
        step(1);
        check_outs("enter.moving", 2'b01, 1'b1, 1'b1, 1'b0);
        step(1);
        check_outs("enter.pulse_end", 2'b01, 1'b1, 1'b0, 1'b0);

        // Ticks while moving do not count
        clear_timer = 1'b1;
        step(1);
        clear_timer = 1'b0;
        step(25);
        check_eq("timer.moving_hold", 32'(study_seconds), 32'd0);

        // Hysteresis on exit
        send(2'b01, 131, 0);
        send(2'b01, 132, 0);
        send(2'b01, 133, 0);
        send(2'b01, 140, 0);
        check_eq("hyst.run_reset", 32'(ch_moving), 32'd1);
        send(2'b01, 141, 0);
        send(2'b01, 142, 0);
        send(2'b01, 143, 0);
        check_outs("hyst.3below", 2'b01, 1'b1, 1'b0, 1'b0);
        send(2'b01, 144, 0);
        check_outs("hyst.exit", 2'b00, 1'b1, 1'b0, 1'b0);
        step(1);
        check_outs("hyst.still_evt", 2'b00, 1'b0, 1'b0, 1'b1);
        step(1);
        check_outs("hyst.evt_end", 2'b00, 1'b0, 1'b0, 1'b0);

        // Mode any/all
        send(2'b01, 150, 0);
        send(2'b01, 160, 0);
        send(2'b01, 170, 0);
        step(1);
        check_outs("any.ch0", 2'b01, 1'b1, 1'b1, 1'b0);
        step(1);
        mode_all = 1'b1;
        step(1);
        check_outs("all.ch0_only", 2'b01, 1'b0, 1'b0, 1'b1);
        step(1);
        check_outs("all.hold", 2'b01, 1'b0, 1'b0, 1'b0);
        send(2'b10, 0, -20);
        send(2'b10, 0, -10);
        send(2'b10, 0, 0);
        check_eq("all.ch1_2runs", 32'(ch_moving), 32'd1);
        send(2'b10, 0, -8);
        check_outs("all.ch1_enter", 2'b11, 1'b0, 1'b0, 1'b0);
        step(1);
        check_outs("all.both", 2'b11, 1'b1, 1'b1, 1'b0);
        mode_all = 1'b0;
        step(2);
        check_outs("any.no_change", 2'b11, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation, then simultaneous priming strobes
        rst = 1'b0;
        step(1);
        check_outs("midrst", 2'b00, 1'b0, 1'b0, 1'b0);
        check_eq("midrst.study", 32'(study_seconds), 32'd0);
        rst = 1'b1;
        send(2'b11, 500, 500);
        check_outs("midrst.prime", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1);
        check_outs("midrst.prime_t2", 2'b00, 1'b0, 1'b0, 1'b0);
        send(2'b11, 510, 490);
        send(2'b11, 520, 480);
        check_eq("midrst.two_runs", 32'(ch_moving), 32'd0);
        send(2'b11, 530, 470);
        check_eq("simul.enter", 32'(ch_moving), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
